// File: rtl/srdhm_pipe_if.sv
// Valid/ready bus for the SRDHM requantization front end.
// The master drives input elements and consumes results; the slave is the pipeline.
interface srdhm_pipe_if #(
  parameter int SIDE_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_acc;
  logic [31:0]       in_bias;
  logic [31:0]       in_mult;
  logic [SIDE_W-1:0] in_side;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [SIDE_W-1:0] out_side;

  modport master (
    output in_valid, in_acc, in_bias, in_mult, in_side, out_ready,
    input  in_ready, out_valid, out_data, out_side
  );

  modport slave (
    input  in_valid, in_acc, in_bias, in_mult, in_side, out_ready,
    output in_ready, out_valid, out_data, out_side
  );
endinterface

// File: rtl/srdhm_pipe.sv
// Three-stage bias-add + saturating rounding doubling high multiply, one element per clock.
// The result is the dividend for the following rounding shift/clamp stage; side carries its exponent code.
module srdhm_pipe #(
  parameter int SIDE_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  srdhm_pipe_if.slave bus
);
  localparam logic [31:0] MIN_Q31 = 32'h8000_0000;
  localparam logic [31:0] MAX_Q31 = 32'h7FFF_FFFF;

  // Round-half-away nudge, then divide by 2^31 truncating toward zero.
  function automatic logic [31:0] srdhm_round(input logic signed [63:0] prod);
    logic signed [63:0] biased;
    logic signed [63:0] adj;
    if (prod >= 64'sd0) begin
      biased = prod + 64'sd1073741824;
    end else begin
      biased = prod - 64'sd1073741823;
    end
    // An arithmetic shift floors; pre-adding 2^31-1 to negatives turns that into truncation.
    if (biased < 64'sd0) begin
      adj = biased + 64'sd2147483647;
    end else begin
      adj = biased;
    end
    return 32'(adj >>> 7'd31);
  endfunction

  logic              v1_r;
  logic              v2_r;
  logic              v3_r;
  logic              adv1_s;
  logic              adv2_s;
  logic              adv3_s;
  logic              in_ready_s;
  logic              take_s;
  logic [31:0]       sum_r;
  logic [31:0]       mult_r;
  logic [SIDE_W-1:0] side1_r;
  logic signed [63:0] prod_r;
  logic              ovf_r;
  logic [SIDE_W-1:0] side2_r;
  logic [31:0]       data_r;
  logic [SIDE_W-1:0] side3_r;
  logic signed [63:0] sum_ext_s;
  logic signed [63:0] mult_ext_s;

  // Ready chain from the output back to the input, and operand sign extension.
  always_comb begin
    adv3_s     = bus.out_ready;
    adv2_s     = !v3_r || adv3_s;
    adv1_s     = !v2_r || adv2_s;
    in_ready_s = !v1_r || adv1_s;
    take_s     = bus.in_valid && in_ready_s;
    sum_ext_s  = {{32{sum_r[31]}}, sum_r};
    mult_ext_s = {{32{mult_r[31]}}, mult_r};
  end

  // Stage valid flags; reset drops every element in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
    end else begin
      if (in_ready_s) begin
        v1_r <= take_s;
      end
      if (adv1_s) begin
        v2_r <= v1_r;
      end
      if (adv2_s) begin
        v3_r <= v2_r;
      end
    end
  end

  // Stage 1 and 2 data registers; qualified by the valid flags, so no reset needed.
  always_ff @(posedge clk) begin
    if (take_s) begin
      sum_r   <= bus.in_acc + bus.in_bias;
      mult_r  <= bus.in_mult;
      side1_r <= bus.in_side;
    end
    if (adv1_s && v1_r) begin
      prod_r  <= sum_ext_s * mult_ext_s;
      ovf_r   <= (sum_r == MIN_Q31) && (mult_r == MIN_Q31);
      side2_r <= side1_r;
    end
  end

  // Output register; holds while the downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r  <= 32'h0000_0000;
      side3_r <= {SIDE_W{1'b0}};
    end else if (adv2_s && v2_r) begin
      data_r  <= ovf_r ? MAX_Q31 : srdhm_round(prod_r);
      side3_r <= side2_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = v3_r;
  assign bus.out_data  = data_r;
  assign bus.out_side  = side3_r;
endmodule

// File: tb/tb_srdhm_pipe.sv
// Self-checking bench for srdhm_pipe: directed vectors, backpressure, reset, and a
// randomized stream scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_srdhm_pipe;
  localparam int SIDE_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [31:0]       exp_q[$];
  logic [SIDE_W-1:0] exps_q[$];

  always #5 clk = ~clk;

  srdhm_pipe_if #(.SIDE_W(SIDE_W)) bus();
  srdhm_pipe #(.SIDE_W(SIDE_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference: plain integer arithmetic on the element's value.
  function automatic logic [31:0] ref_srdhm(input logic [31:0] acc, input logic [31:0] bias,
                                            input logic [31:0] mult);
    logic [31:0] s32;
    longint s, m, p, q;
    s32 = acc + bias;
    s = longint'($signed(s32));
    m = longint'($signed(mult));
    if (s == -64'sd2147483648 && m == -64'sd2147483648) return 32'h7FFF_FFFF;
    p = s * m;
    if (p >= 0) p = p + 64'sd1073741824;
    else p = p + 64'sd1 - 64'sd1073741824;
    q = p / 64'sd2147483648;
    return q[31:0];
  endfunction

  task automatic drive_cycle(input logic iv, input logic [31:0] acc, input logic [31:0] bias,
                             input logic [31:0] mult, input logic [SIDE_W-1:0] side,
                             input logic ordy, output logic in_fire, output logic out_fire,
                             output logic ov, output logic [31:0] od,
                             output logic [SIDE_W-1:0] os, output logic ir);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_acc    = acc;
    bus.in_bias   = bias;
    bus.in_mult   = mult;
    bus.in_side   = side;
    bus.out_ready = ordy;
    #1;
    ir = bus.in_ready;
    ov = bus.out_valid;
    od = bus.out_data;
    os = bus.out_side;
    in_fire  = iv && ir;
    out_fire = ov && ordy;
    if (in_fire) begin
      exp_q.push_back(ref_srdhm(acc, bias, mult));
      exps_q.push_back(side);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_acc = 32'd0; bus.in_bias = 32'd0; bus.in_mult = 32'd0; bus.in_side = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_side !== 4'h0) begin n_fail++; $display("FAIL reset_out_side: got %h want 0", bus.out_side); end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] va[4], vb[4], vm[4], vexp[4];
    logic [SIDE_W-1:0] vs[4];
    logic inf, of, ov, ir, got;
    logic [31:0] od, gd;
    logic [SIDE_W-1:0] os, gs;
    int lat;
    va   = '{32'd1000, 32'hFFFF_FC00, 32'h8000_0000, 32'h7FFF_FFFF};
    vb   = '{32'd24, 32'd0, 32'd0, 32'd1};
    vm   = '{32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 32'h4000_0000};
    vs   = '{4'd3, 4'd5, 4'd7, 4'd9};
    vexp = '{32'd512, 32'hFFFF_FE00, 32'h7FFF_FFFF, 32'hC000_0000};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, va[i], vb[i], vm[i], vs[i], 1'b1, inf, of, ov, od, os, ir);
      n_cmp++; if (inf !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept: in_ready %b want 1", i, ir); end
      got = 1'b0; lat = 0; gd = 32'h0; gs = '0;
      for (int c = 1; c <= 8 && !got; c++) begin
        drive_cycle(1'b0, 32'd0, 32'd0, 32'd0, '0, 1'b1, inf, of, ov, od, os, ir);
        if (ov) begin got = 1'b1; lat = c; gd = od; gs = os; end
      end
      if (got && exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exps_q.pop_front()); end
      n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 3", i, lat); end
      n_cmp++; if (gd !== vexp[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, gd, vexp[i]); end
      n_cmp++; if (gs !== vs[i]) begin n_fail++; $display("FAIL dir%0d_side: got %h want %h", i, gs, vs[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic inf, of, ov, ir;
    logic [31:0] od, e;
    logic [SIDE_W-1:0] os, es;
    for (int c = 0; c < 26; c++) begin
      drive_cycle(c < 20, $urandom, $urandom, $urandom, SIDE_W'($urandom_range(0, 15)), 1'b1,
                  inf, of, ov, od, os, ir);
      if (c < 20) begin
        n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, ir); end
      end
      n_cmp++;
      if (ov !== (c >= 3 && c < 23)) begin
        n_fail++; $display("FAIL b2b_out_valid c%0d: got %b want %b", c, ov, (c >= 3 && c < 23));
      end
      if (of) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_extra: got %h want none", od); end
        else begin
          e = exp_q.pop_front(); es = exps_q.pop_front();
          if (od !== e || os !== es) begin n_fail++; $display("FAIL b2b_data: got %h/%h want %h/%h", od, os, e, es); end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic inf, of, ov, ir, ordy, iv, pov, pordy;
    logic [31:0] od, e, pod;
    logic [SIDE_W-1:0] os, es, pos;
    int sent, outs, drop_at;
    sent = 0; outs = 0; drop_at = -1; pov = 1'b0; pordy = 1'b1; pod = 32'h0; pos = '0;
    for (int c = 1; c <= 40; c++) begin
      ordy = !(c >= 2 && c <= 8);
      iv = (sent < 6);
      drive_cycle(iv, $urandom, $urandom, $urandom, SIDE_W'(sent + 1), ordy, inf, of, ov, od, os, ir);
      if (iv && !ir && drop_at < 0) drop_at = sent;
      if (inf) sent++;
      if (pov && !pordy) begin
        n_cmp++;
        if (!ov || od !== pod || os !== pos) begin
          n_fail++; $display("FAIL bp_hold c%0d: got %b/%h/%h want 1/%h/%h", c, ov, od, os, pod, pos);
        end
      end
      if (of) begin
        n_cmp++; outs++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_extra: got %h want none", od); end
        else begin
          e = exp_q.pop_front(); es = exps_q.pop_front();
          if (od !== e || os !== es) begin n_fail++; $display("FAIL bp_data: got %h/%h want %h/%h", od, os, e, es); end
        end
      end
      pov = ov; pordy = ordy; pod = od; pos = os;
    end
    n_cmp++; if (drop_at != 3) begin n_fail++; $display("FAIL bp_ready_drop: got %0d want 3", drop_at); end
    n_cmp++; if (sent != 6) begin n_fail++; $display("FAIL bp_sent: got %0d want 6", sent); end
    n_cmp++; if (outs != 6) begin n_fail++; $display("FAIL bp_outs: got %0d want 6", outs); end
  endtask

  task automatic test_random;
    logic inf, of, ov, ir, ordy, iv, pov, pordy;
    logic [31:0] od, e, pod, a, b, m;
    logic [SIDE_W-1:0] os, es, pos;
    int sel;
    pov = 1'b0; pordy = 1'b1; pod = 32'h0; pos = '0;
    for (int c = 0; c < 340; c++) begin
      iv   = (c < 300) && ($urandom_range(0, 3) != 0);
      ordy = (c >= 300) || ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom; m = $urandom;
      if (sel == 0) begin a = 32'h8000_0000; b = 32'd0; m = 32'h8000_0000; end
      else if (sel == 1) begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 9); end
      else if (sel == 2) begin b = 32'd0; m = 32'h8000_0000; end
      else if (sel == 3) begin a = $urandom_range(0, 4095) - 2048; b = 32'd0; end
      drive_cycle(iv, a, b, m, SIDE_W'($urandom_range(0, 15)), ordy, inf, of, ov, od, os, ir);
      if (pov && !pordy) begin
        n_cmp++;
        if (!ov || od !== pod || os !== pos) begin
          n_fail++; $display("FAIL rnd_hold c%0d: got %b/%h/%h want 1/%h/%h", c, ov, od, os, pod, pos);
        end
      end
      if (of) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra: got %h want none", od); end
        else begin
          e = exp_q.pop_front(); es = exps_q.pop_front();
          if (od !== e || os !== es) begin n_fail++; $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, od, os, e, es); end
        end
      end
      pov = ov; pordy = ordy; pod = od; pos = os;
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midstream;
    logic inf, of, ov, ir;
    logic [31:0] od;
    logic [SIDE_W-1:0] os;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, $urandom, $urandom, $urandom, 4'd6, 1'b0, inf, of, ov, od, os, ir);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_full: got %b want 1", bus.out_valid); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    #2 reset = 1'b0;
    exp_q.delete(); exps_q.delete();
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, $urandom, $urandom, $urandom, '0, 1'b1, inf, of, ov, od, os, ir);
      n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL mid_stale c%0d: got %b want 0", c, ov); end
      n_cmp++; if (ir !== 1'b1) begin n_fail++; $display("FAIL mid_ready c%0d: got %b want 1", c, ir); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/srdhm_pipe.md
Name: srdhm_pipe

Overview:
- Three-stage pipelined requantization front end for the KWS int8 output path.
- Per output element: adds the per-channel bias to the 32-bit accumulator, then computes the saturating rounding doubling high multiply (SRDHM) against the per-channel quantized multiplier.
- Feeds the rounding divide-by-power-of-two / clamp stage directly: `out_data` is that stage's dividend, and `out_side` carries its shift-exponent code.
- Valid/ready handshake on both sides, full throughput of one element per clock.

Parameters:
- `SIDE_W`, 4, width of the sideband field (the exponent code) carried alongside each element, unmodified.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input element present
- `in_ready`  out  1  stage 1 can accept this cycle
- `in_acc`  in  32  signed accumulator
- `in_bias`  in  32  signed per-channel bias
- `in_mult`  in  32  signed quantized multiplier (Q31)
- `in_side`  in  `SIDE_W`  sideband (exponent code), passed through
- `out_valid`  out  1  result present
- `out_ready`  in  1  downstream accepts
- `out_data`  out  32  signed SRDHM result
- `out_side`  out  `SIDE_W`  sideband matching `out_data`

Behaviour:
- Reset is asynchronous and active-high on `reset`.
  - While asserted: all stage valid flags clear, so `out_valid=0` and `in_ready=1`.
  - `out_data` and `out_side` reset to 0.
  - Data registers other than the outputs need no reset.
  - Reset mid-stream discards every in-flight element; none is emitted after release.
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Stages: each has a valid flag `v1`, `v2`, `v3`. Stage k advances when `!v(k+1)` or stage k+1 advances. Stage 3 advances when `out_ready`.
  - `in_ready = !v1 || stage1_advances`. This is the combinational ready chain from `out_ready`; no bubbles under continuous flow.
- S1 register:
  - `sum = in_acc + in_bias`, 32-bit two's-complement, wraps with no saturation.
  - Also registers `mult` and `side`.
- S2 register:
  - `prod = sum * mult`, full signed 64-bit product.
  - Register flag `ovf = (sum == 32'h80000000) && (mult == 32'h80000000)`.
- S3 register, i.e. the output:
  - `nudge = prod >= 0 ? 2^30 : 1 - 2^30`.
  - `q = (prod + nudge) / 2^31`, signed division truncating toward zero. This is NOT an arithmetic shift; negative values round toward zero.
  - `out_data = ovf ? 32'h7FFFFFFF : q[31:0]`.
- Latency: 3 cycles from input transfer to `out_valid` when not stalled.
- Ordering is strictly FIFO; there is no reordering or dropping.
- Stall (`out_ready=0`):
  - S3 holds `out_data`/`out_side` stable while `out_valid=1`.
  - Upstream stages fill. `in_ready` falls once S1–S3 are all valid and blocked.
- Outputs must not change while `out_valid && !out_ready`.
- Simultaneous input and output transfer in the same cycle with a full pipe: accepted, and the pipe stays full.
- Inputs are sampled only on transfer; values on the bus while `in_valid=0` are ignored.

Test Plan:
- `acc=1000`, `bias=24`, `mult=32'h40000000`, `side=3` → 3 cycles later `out_data=512`, `out_side=3`.
- `acc=-1024`, `bias=0`, `mult=32'h40000000` → `out_data=-512` (`32'hFFFFFE00`); checks toward-zero rounding of negatives.
- `acc=32'h80000000`, `bias=0`, `mult=32'h80000000` → `out_data=32'h7FFFFFFF` (saturation case).
- `acc=32'h7FFFFFFF`, `bias=1`, `mult=32'h40000000` → bias wraps to `32'h80000000` → `out_data=32'hC0000000`.
- Backpressure:
  - Stimulus: stream 6 back-to-back elements with `out_ready=0` for cycles 2–8, then 1.
  - Required: `in_ready` drops after 3 accepted with the pipe full; outputs are held stable while stalled; all 6 emerge in order with correct values and no duplicates.
- Reset mid-stream: assert `reset` with 3 elements in flight → `out_valid=0` immediately; after release `in_ready=1`, and no stale element appears in the next 5 cycles.
